seg7_scan_ctrl: RTL and testbench

- Time-multiplexes one physical 7-segment bus between the units and tens digits driven by the team's 4-bit binary-to-two-digit 7-seg decoder (input 0..15, outputs units/tens segment patterns).
- Holds the value shown and feeds it to the decoder. Scans the two digit anodes with a dead-time gap between digits. Applies new values only at frame boundaries, so a digit pair never tears.
- Sits between the value producer (counter/FSM logic) and the board's segment/anode pins.

---
 rtl/seg7_scan_ctrl_if.sv | 29 ++
 rtl/seg7_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_ctrl_if                                                |
// | Value-load / decoder / display-pin bundle for seg7_scan_ctrl.    |
// | Rev 1.0  initial release                                         |
// +------------------------------------------------------------------+
interface seg7_scan_ctrl_if;
   logic       en;
   logic       load;
   logic [3:0] value_in;
   logic [3:0] dec_val;
   logic [6:0] seg_units;
   logic [6:0] seg_tens;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_ack;

   // Producer side: value source plus the external decoder's patterns.
   modport master (
      output en, load, value_in, seg_units, seg_tens,
      input  dec_val, seg, an, frame_ack
   );

   modport slave (
      input  en, load, value_in, seg_units, seg_tens,
      output dec_val, seg, an, frame_ack
   );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_ctrl                                                   |
// | Two-digit 7-seg scanner with gap time and frame-aligned commits. |
// | Rev 1.0  initial release                                         |
// +------------------------------------------------------------------+
module seg7_scan_ctrl #(
   parameter int SLOT_CYCLES    = 50000,
   parameter int GAP_CYCLES     = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   seg7_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      SHOW_U = 2'd0,
      GAP_U  = 2'd1,
      SHOW_T = 2'd2,
      GAP_T  = 2'd3
   } state_t;

   localparam int c_CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX);
   localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SLOT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
   localparam logic [6:0]         c_BLANK     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t             r_state;
   state_t             w_nextState;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_nextCnt;
   logic               w_lastCycle;
   logic               w_frameEnd;
   logic               w_commit;
   logic [3:0]         r_shadow;
   logic               r_pending;
   logic [3:0]         r_decVal;
   logic               r_frameAck;
   logic               w_tensBlank;
   logic [6:0]         w_seg;
   logic [1:0]         w_an;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SHOW_U;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt + 1'b1;
      w_lastCycle = (r_state == SHOW_U || r_state == SHOW_T) ? (r_cnt == c_SLOT_LAST)
                                                             : (r_cnt == c_GAP_LAST);
      if (!bus.en) begin
         // Disabled display parks at the start of a frame so re-enable is deterministic.
         w_nextState = SHOW_U;
         w_nextCnt   = '0;
      end else if (w_lastCycle) begin
         w_nextCnt = '0;
         case (r_state)
            SHOW_U:  w_nextState = GAP_U;
            GAP_U:   w_nextState = SHOW_T;
            SHOW_T:  w_nextState = GAP_T;
            GAP_T:   w_nextState = SHOW_U;
            default: w_nextState = SHOW_U;
         endcase
      end
   end

   assign w_frameEnd = bus.en && (r_state == GAP_T) && w_lastCycle;
   assign w_commit   = r_pending && (!bus.en || w_frameEnd);

   // A load on the commit edge lands in shadow while the old shadow commits,
   // so pending stays set and the new value waits for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow   <= '0;
         r_pending  <= 1'b0;
         r_decVal   <= '0;
         r_frameAck <= 1'b0;
      end else begin
         r_frameAck <= w_commit;
         if (w_commit) begin
            r_decVal <= r_shadow;
         end
         if (bus.load) begin
            r_shadow  <= bus.value_in;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign w_tensBlank = BLANK_LZ && (r_decVal < 4'd10);

   always_comb begin
      w_an  = 2'b11;
      w_seg = c_BLANK;
      if (bus.en) begin
         case (r_state)
            SHOW_U: begin
               w_an  = 2'b10;
               w_seg = bus.seg_units;
            end
            SHOW_T: begin
               if (!w_tensBlank) begin
                  w_an  = 2'b01;
                  w_seg = bus.seg_tens;
               end
            end
            default: begin
               w_an  = 2'b11;
               w_seg = c_BLANK;
            end
         endcase
      end
   end

   assign bus.an        = w_an;
   assign bus.seg       = w_seg;
   assign bus.dec_val   = r_decVal;
   assign bus.frame_ack = r_frameAck;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seg7_scan_ctrl                                                |
// | Table-driven bench for seg7_scan_ctrl (SLOT=4, GAP=1).           |
// | Rev 1.0  initial release                                         |
// +------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

   typedef struct {
      logic       en;
      logic       load;
      logic [3:0] val;
      logic [1:0] an;
      logic [3:0] dec;
      logic       ack;
   } vec_t;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nPass;
   int   pos;
   int   ackSeen;
   int   decBad;
   vec_t vecs[$];

   seg7_scan_ctrl_if bus ();

   seg7_scan_ctrl #(
      .SLOT_CYCLES   (4),
      .GAP_CYCLES    (1),
      .SEG_ACTIVE_LOW(1'b1),
      .BLANK_LZ      (1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-high gfedcba patterns for one decimal digit.
   function automatic logic [6:0] segPat(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] unitsPat(input logic [3:0] v);
      return ~segPat(4'(v % 4'd10));
   endfunction

   function automatic logic [6:0] tensPat(input logic [3:0] v);
      return ~segPat(4'(v / 4'd10));
   endfunction

   // Stand-in for the combinational binary-to-two-digit decoder.
   assign bus.seg_units = unitsPat(bus.dec_val);
   assign bus.seg_tens  = tensPat(bus.dec_val);

   function automatic logic [1:0] anAt(input int p, input logic [3:0] d);
      if (p < 4) return 2'b10;
      if (p == 4 || p == 9) return 2'b11;
      return (d >= 4'd10) ? 2'b01 : 2'b11;
   endfunction

   function automatic logic [6:0] expSeg(input logic [1:0] a, input logic [3:0] d);
      if (a == 2'b10) return unitsPat(d);
      if (a == 2'b01) return tensPat(d);
      return 7'h7F;
   endfunction

   task automatic push(input logic ld, input logic [3:0] v, input logic [3:0] d, input logic ak);
      vec_t r;
      pos    = (pos + 1) % 10;
      r.en   = 1'b1;
      r.load = ld;
      r.val  = v;
      r.an   = anAt(pos, d);
      r.dec  = d;
      r.ack  = ak;
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOut(input string tag, input logic [1:0] a, input logic [3:0] d, input logic ak);
      check({tag, ".an"},  int'(bus.an), int'(a));
      check({tag, ".seg"}, int'(bus.seg), int'(expSeg(a, d)));
      check({tag, ".dec"}, int'(bus.dec_val), int'(d));
      check({tag, ".ack"}, int'(bus.frame_ack), int'(ak));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      nChecks = 0;
      nPass   = 0;
      pos     = 0;

      // Frame 1: idle scan of value 0, tens blanked.
      repeat (10) push(1'b0, 4'd0, 4'd0, 1'b0);
      // Load 13 mid-SHOW_U, commit at the frame boundary.
      push(1'b1, 4'd13, 4'd0, 1'b0);
      repeat (8) push(1'b0, 4'd0, 4'd0, 1'b0);
      push(1'b0, 4'd0, 4'd13, 1'b1);
      // Loads 7 then 12 in one frame: only 12 commits.
      push(1'b1, 4'd7, 4'd13, 1'b0);
      push(1'b0, 4'd0, 4'd13, 1'b0);
      push(1'b1, 4'd12, 4'd13, 1'b0);
      repeat (6) push(1'b0, 4'd0, 4'd13, 1'b0);
      push(1'b0, 4'd0, 4'd12, 1'b1);
      push(1'b0, 4'd0, 4'd12, 1'b0);
      // Load 5, then load 9 on the commit edge itself.
      push(1'b1, 4'd5, 4'd12, 1'b0);
      repeat (7) push(1'b0, 4'd0, 4'd12, 1'b0);
      push(1'b1, 4'd9, 4'd5, 1'b1);
      repeat (9) push(1'b0, 4'd0, 4'd5, 1'b0);
      push(1'b0, 4'd0, 4'd9, 1'b1);

      rst_n        = 1'b0;
      bus.en       = 1'b1;
      bus.load     = 1'b0;
      bus.value_in = 4'd0;
      #12;
      checkOut("reset", 2'b10, 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.en       = vecs[i].en;
         bus.load     = vecs[i].load;
         bus.value_in = vecs[i].val;
         tick();
         checkOut($sformatf("vec%0d", i), vecs[i].an, vecs[i].dec, vecs[i].ack);
      end

      // en=0 with 4 pending commits on the next edge.
      bus.load     = 1'b1;
      bus.value_in = 4'd4;
      tick();
      checkOut("ld4", 2'b10, 4'd9, 1'b0);
      bus.load = 1'b0;
      bus.en   = 1'b0;
      #1;
      checkOut("dis0", 2'b11, 4'd9, 1'b0);
      tick();
      checkOut("dis1", 2'b11, 4'd4, 1'b1);
      tick();
      checkOut("dis2", 2'b11, 4'd4, 1'b0);
      bus.en = 1'b1;
      #1;
      checkOut("ren0", 2'b10, 4'd4, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         checkOut($sformatf("ren%0d", k), 2'b10, 4'd4, 1'b0);
      end
      tick();
      checkOut("ren4", 2'b11, 4'd4, 1'b0);

      // Reset mid-SHOW_T with 11 pending: value is lost, no ack ever follows.
      tick();
      bus.load     = 1'b1;
      bus.value_in = 4'd11;
      tick();
      bus.load = 1'b0;
      checkOut("preRst", 2'b11, 4'd4, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOut("midRst", 2'b10, 4'd0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      ackSeen = 0;
      decBad  = 0;
      repeat (25) begin
         tick();
         if (bus.frame_ack) ackSeen++;
         if (bus.dec_val != 4'd0) decBad++;
      end
      check("postRst.ackCount", ackSeen, 0);
      check("postRst.decChanges", decBad, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
